dma_seg_ram_rd_wr: RTL and testbench
====================================

Name: dma_seg_ram_rd_wr

Overview:
Segmented dual-port RAM that serves as the DMA data buffer directly upstream of the DMA client AXI-stream source. It serves that block's per-segment read command/response interface, and a write port used by the DMA interface to fill the buffer. Each segment is an independent RAM bank with its own pipelined, backpressure-capable read path and byte-enable write path.

Parameters:
SEG_COUNT, 4, number of RAM segments (banks)
SEG_DATA_WIDTH, 128, data width per segment, bits
SEG_ADDR_WIDTH, 12, word address width per segment (depth 2^SEG_ADDR_WIDTH)
SEG_BE_WIDTH, SEG_DATA_WIDTH/8, byte enables per segment
PIPELINE, 2, read pipeline depth in registers, minimum 1

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  reset, asynchronous, active-high
wr_cmd_be  in  SEG_COUNT*SEG_BE_WIDTH  per-segment write byte enables
wr_cmd_addr  in  SEG_COUNT*SEG_ADDR_WIDTH  per-segment write word address
wr_cmd_data  in  SEG_COUNT*SEG_DATA_WIDTH  per-segment write data
wr_cmd_valid  in  SEG_COUNT  per-segment write command valid
wr_cmd_ready  out  SEG_COUNT  per-segment write command ready
wr_done  out  SEG_COUNT  per-segment write completion pulse
rd_cmd_addr  in  SEG_COUNT*SEG_ADDR_WIDTH  per-segment read word address
rd_cmd_valid  in  SEG_COUNT  per-segment read command valid
rd_cmd_ready  out  SEG_COUNT  per-segment read command ready
rd_resp_data  out  SEG_COUNT*SEG_DATA_WIDTH  per-segment read data
rd_resp_valid  out  SEG_COUNT  per-segment read response valid
rd_resp_ready  in  SEG_COUNT  per-segment read response ready

Behaviour:
- Reset is asynchronous and active-high on rst.
- Reset values: wr_cmd_ready=0, wr_done=0, rd_cmd_ready=0, rd_resp_valid=0, and all pipeline valid bits = 0.
- rd_resp_data is unspecified while rd_resp_valid=0. Memory contents are not cleared by reset.
- All segments are fully independent; all rules below apply per segment.
- Write:
  - wr_cmd_ready=1 whenever not in reset.
  - Write accepted on valid&ready; byte j written iff be[j]=1; be=0 is accepted but writes nothing.
  - wr_done pulses high for exactly 1 cycle, the cycle after acceptance, including be=0.
- Read pipeline: PIPELINE stages, each a data register plus a valid bit.
  - Stage 0 loads mem[rd_cmd_addr] on command acceptance.
  - The last stage drives rd_resp_data/rd_resp_valid.
- Advance rule:
  - Last stage may load when it is empty or rd_resp_ready=1.
  - Stage i may load when it is empty or stage i+1 loads.
  - A stage that does not load holds its data and valid unchanged.
  - A stage that loads from an empty predecessor becomes invalid.
- rd_cmd_ready = stage 0 may load (combinational from the valid bits and rd_resp_ready); forced 0 during reset.
- Latency: with rd_resp_ready held 1, a command accepted in cycle N gives rd_resp_valid=1 in cycle N+PIPELINE.
- Throughput: 1 read per cycle per segment, sustained.
- Backpressure: at most PIPELINE outstanding responses per segment; rd_cmd_ready drops once all stages are full and rd_resp_ready=0.
- Responses are returned strictly in command order; none are dropped or duplicated.
- Read and write to the same address in the same cycle: the read returns the old data (read-first). A read accepted on a later cycle returns the new data.
- Address range: the full 2^SEG_ADDR_WIDTH range, no wrap logic needed; the top address is valid.
- Reset mid-operation: all in-flight reads are discarded and rd_resp_valid drops asynchronously. Writes already accepted remain in memory.

Test Plan:
- Write then read: seg0 write addr 0x010, data 0x00112233445566778899AABBCCDDEEFF, be all 1s; seg0 read 0x010 -> wr_done pulse 1 cycle after accept; read data equal, rd_resp_valid exactly 2 cycles after read accept (PIPELINE=2).
- Byte enables: write 0xFF..FF to addr 5, then data 0 with be=0x000F -> read returns 0xFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_0000_0000. Then be=0 write -> wr_done pulses, data unchanged.
- Backpressure: hold rd_resp_ready=0 and issue reads to addrs 1,2,3 on seg2 -> 2 accepted then rd_cmd_ready=0. Release ready -> responses arrive in order 1,2,3 with no gaps once streaming.
- Parallel segments: simultaneous reads on all 4 segments at addr 0xFFF, seg3 backpressured -> segs 0-2 respond in cycle N+2; seg3 holds data stable until ready.
- Read/write collision: same cycle, write 0xAA.. and read addr 7 (old 0x55..) -> response 0x55..; next-cycle read -> 0xAA...
- Reset mid-flight: 2 reads outstanding, assert rst -> rd_resp_valid=0 immediately. After release, no stale responses appear, rd_cmd_ready=1, and memory contents are preserved.

Source files
------------

// File: rtl/dma_seg_ram_rd_wr.sv
// Segmented dual-port DMA buffer RAM: per-segment byte-enable write port and
// a pipelined, backpressure-capable read path. Segments are fully independent.
module dma_seg_ram_rd_wr #(
  parameter int SEG_COUNT      = 4,
  parameter int SEG_DATA_WIDTH = 128,
  parameter int SEG_ADDR_WIDTH = 12,
  parameter int SEG_BE_WIDTH   = SEG_DATA_WIDTH/8,
  parameter int PIPELINE       = 2
) (
  input  logic                                clk,
  input  logic                                rst,

  input  logic [SEG_COUNT*SEG_BE_WIDTH-1:0]   wr_cmd_be,
  input  logic [SEG_COUNT*SEG_ADDR_WIDTH-1:0] wr_cmd_addr,
  input  logic [SEG_COUNT*SEG_DATA_WIDTH-1:0] wr_cmd_data,
  input  logic [SEG_COUNT-1:0]                wr_cmd_valid,
  output logic [SEG_COUNT-1:0]                wr_cmd_ready,
  output logic [SEG_COUNT-1:0]                wr_done,

  input  logic [SEG_COUNT*SEG_ADDR_WIDTH-1:0] rd_cmd_addr,
  input  logic [SEG_COUNT-1:0]                rd_cmd_valid,
  output logic [SEG_COUNT-1:0]                rd_cmd_ready,
  output logic [SEG_COUNT*SEG_DATA_WIDTH-1:0] rd_resp_data,
  output logic [SEG_COUNT-1:0]                rd_resp_valid,
  input  logic [SEG_COUNT-1:0]                rd_resp_ready
);

  localparam int DW = SEG_DATA_WIDTH;
  localparam int AW = SEG_ADDR_WIDTH;
  localparam int BW = SEG_BE_WIDTH;

  // The write port never stalls; it is only closed while reset is asserted.
  assign wr_cmd_ready = {SEG_COUNT{~rst}};

  for (genvar s = 0; s < SEG_COUNT; s++) begin : g_seg
    logic [DW-1:0]       mem [0:(2**AW)-1];
    logic [AW-1:0]       wr_addr;
    logic [AW-1:0]       rd_addr;
    logic [BW-1:0]       wr_be;
    logic [DW-1:0]       wr_data;
    logic                wr_acc;
    logic                rd_acc;
    logic                wr_done_q;
    logic [DW-1:0]       stage_data [PIPELINE];
    logic [PIPELINE-1:0] stage_valid;
    logic [PIPELINE-1:0] stage_ld;

    assign wr_addr = wr_cmd_addr[s*AW +: AW];
    assign rd_addr = rd_cmd_addr[s*AW +: AW];
    assign wr_be   = wr_cmd_be[s*BW +: BW];
    assign wr_data = wr_cmd_data[s*DW +: DW];

    assign wr_acc  = wr_cmd_valid[s] & wr_cmd_ready[s];
    assign rd_acc  = rd_cmd_valid[s] & rd_cmd_ready[s];

    // NOTE: the RAM array and the read data registers have no reset; only
    // control state (valid bits, done pulse) is reset, so they map onto block RAM.
    always_ff @(posedge clk) begin
      if (wr_acc) begin
        for (int j = 0; j < BW; j++) begin
          if (wr_be[j]) mem[wr_addr][j*8 +: 8] <= wr_data[j*8 +: 8];
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) wr_done_q <= 1'b0;
      else     wr_done_q <= wr_acc;
    end

    // A stage may load when empty or when its successor is loading; evaluated
    // from the output end so a full pipe drains and refills in the same cycle.
    always_comb begin
      logic ld;
      // NOTE: every always_comb output is assigned a default first so no
      // path can leave it holding a value, which would infer a latch.
      stage_ld = '0;
      ld = ~stage_valid[PIPELINE-1] | rd_resp_ready[s];
      stage_ld[PIPELINE-1] = ld;
      for (int i = PIPELINE-2; i >= 0; i--) begin
        ld = ~stage_valid[i] | ld;
        stage_ld[i] = ld;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        stage_valid <= '0;
      end else begin
        if (stage_ld[0]) stage_valid[0] <= rd_acc;
        for (int i = 1; i < PIPELINE; i++) begin
          if (stage_ld[i]) stage_valid[i] <= stage_valid[i-1];
        end
      end
    end

    // Non-blocking read of mem gives read-first behaviour on a same-cycle
    // write to the same address.
    always_ff @(posedge clk) begin
      if (stage_ld[0] && rd_acc) stage_data[0] <= mem[rd_addr];
      for (int i = 1; i < PIPELINE; i++) begin
        if (stage_ld[i]) stage_data[i] <= stage_data[i-1];
      end
    end

    assign wr_done[s]               = wr_done_q;
    assign rd_cmd_ready[s]          = stage_ld[0] & ~rst;
    assign rd_resp_valid[s]         = stage_valid[PIPELINE-1];
    assign rd_resp_data[s*DW +: DW] = stage_data[PIPELINE-1];
  end

endmodule

// File: tb/tb_dma_seg_ram_rd_wr.sv
// Directed bench for dma_seg_ram_rd_wr: table of write/read vectors plus
// hand-written backpressure, parallel, collision and reset sequences.
module tb_dma_seg_ram_rd_wr;

  localparam int SC = 4;
  localparam int DW = 128;
  localparam int AW = 12;
  localparam int BW = DW/8;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [SC*BW-1:0]     wr_cmd_be    = '0;
  logic [SC*AW-1:0]     wr_cmd_addr  = '0;
  logic [SC*DW-1:0]     wr_cmd_data  = '0;
  logic [SC-1:0]        wr_cmd_valid = '0;
  logic [SC-1:0]        wr_cmd_ready;
  logic [SC-1:0]        wr_done;
  logic [SC*AW-1:0]     rd_cmd_addr  = '0;
  logic [SC-1:0]        rd_cmd_valid = '0;
  logic [SC-1:0]        rd_cmd_ready;
  logic [SC*DW-1:0]     rd_resp_data;
  logic [SC-1:0]        rd_resp_valid;
  logic [SC-1:0]        rd_resp_ready = '1;

  int n_checks = 0;
  int n_fail   = 0;

  dma_seg_ram_rd_wr #(
    .SEG_COUNT(SC), .SEG_DATA_WIDTH(DW), .SEG_ADDR_WIDTH(AW), .PIPELINE(2)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_cmd_be(wr_cmd_be), .wr_cmd_addr(wr_cmd_addr), .wr_cmd_data(wr_cmd_data),
    .wr_cmd_valid(wr_cmd_valid), .wr_cmd_ready(wr_cmd_ready), .wr_done(wr_done),
    .rd_cmd_addr(rd_cmd_addr), .rd_cmd_valid(rd_cmd_valid), .rd_cmd_ready(rd_cmd_ready),
    .rd_resp_data(rd_resp_data), .rd_resp_valid(rd_resp_valid), .rd_resp_ready(rd_resp_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int          seg;
    logic [11:0] addr;
    logic [DW-1:0] data;
    logic [15:0] be;
    bit          do_rd;
    logic [DW-1:0] exp;
  } vec_t;

  localparam logic [DW-1:0] D_HELLO = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [DW-1:0] D_ONES  = {DW{1'b1}};
  localparam logic [DW-1:0] D_A     = 128'h0123456789ABCDEF_FEDCBA9876543210;
  localparam logic [DW-1:0] D_B     = {16{8'h5A}};
  localparam logic [DW-1:0] D_55    = {16{8'h55}};
  localparam logic [DW-1:0] D_AA    = {16{8'hAA}};
  localparam logic [DW-1:0] D_S0    = 128'hC0C0C0C0_00000000_00000000_00000FFF;
  localparam logic [DW-1:0] D_S1    = 128'hC1C1C1C1_11111111_11111111_11111FFF;
  localparam logic [DW-1:0] D_S2    = 128'hC2C2C2C2_22222222_22222222_22222FFF;
  localparam logic [DW-1:0] D_S3    = 128'hC3C3C3C3_33333333_33333333_33333FFF;
  localparam logic [DW-1:0] D_R1    = {4{32'h1111_0001}};
  localparam logic [DW-1:0] D_R2    = {4{32'h2222_0002}};
  localparam logic [DW-1:0] D_R3    = {4{32'h3333_0003}};

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] seg_data(input int seg);
    return rd_resp_data[seg*DW +: DW];
  endfunction

  task automatic do_write(input int seg, input logic [11:0] addr,
                          input logic [DW-1:0] data, input logic [15:0] be);
    wr_cmd_addr[seg*AW +: AW] = addr;
    wr_cmd_data[seg*DW +: DW] = data;
    wr_cmd_be[seg*BW +: BW]   = be;
    wr_cmd_valid[seg]         = 1'b1;
    #1;
    check("wr_cmd_ready", DW'(wr_cmd_ready[seg]), DW'(1));
    tick;
    wr_cmd_valid = '0;
    check("wr_done_pulse", DW'(wr_done), DW'(4'b0001 << seg));
    tick;
    check("wr_done_clear", DW'(wr_done), '0);
  endtask

  task automatic do_read(input int seg, input logic [11:0] addr, input logic [DW-1:0] exp);
    rd_cmd_addr[seg*AW +: AW] = addr;
    rd_cmd_valid[seg]         = 1'b1;
    #1;
    check("rd_cmd_ready", DW'(rd_cmd_ready[seg]), DW'(1));
    tick;
    rd_cmd_valid = '0;
    check("rd_lat_n1", DW'(rd_resp_valid[seg]), DW'(0));
    tick;
    check("rd_lat_n2", DW'(rd_resp_valid[seg]), DW'(1));
    check("rd_data", seg_data(seg), exp);
    tick;
    check("rd_valid_drop", DW'(rd_resp_valid[seg]), DW'(0));
  endtask

  vec_t vecs[$];

  initial begin
    vecs.push_back('{0, 12'h010, D_HELLO, 16'hFFFF, 1'b1, D_HELLO});
    vecs.push_back('{0, 12'h005, D_ONES,  16'hFFFF, 1'b1, D_ONES});
    vecs.push_back('{0, 12'h005, '0,      16'h000F, 1'b1, {96'hFFFFFFFF_FFFFFFFF_FFFFFFFF, 32'h0}});
    vecs.push_back('{0, 12'h005, '0,      16'h0000, 1'b1, {96'hFFFFFFFF_FFFFFFFF_FFFFFFFF, 32'h0}});
    vecs.push_back('{3, 12'h123, D_A,     16'hFFFF, 1'b0, '0});
    vecs.push_back('{3, 12'h123, D_B,     16'h8001, 1'b1, 128'h5A23456789ABCDEF_FEDCBA987654325A});
    vecs.push_back('{0, 12'h007, D_55,    16'hFFFF, 1'b1, D_55});
    vecs.push_back('{2, 12'h001, D_R1,    16'hFFFF, 1'b0, '0});
    vecs.push_back('{2, 12'h002, D_R2,    16'hFFFF, 1'b0, '0});
    vecs.push_back('{2, 12'h003, D_R3,    16'hFFFF, 1'b0, '0});
    vecs.push_back('{0, 12'hFFF, D_S0,    16'hFFFF, 1'b0, '0});
    vecs.push_back('{1, 12'hFFF, D_S1,    16'hFFFF, 1'b1, D_S1});
    vecs.push_back('{2, 12'hFFF, D_S2,    16'hFFFF, 1'b0, '0});
    vecs.push_back('{3, 12'hFFF, D_S3,    16'hFFFF, 1'b0, '0});

    // Reset state
    #3;
    check("rst_wr_cmd_ready",  DW'(wr_cmd_ready),  '0);
    check("rst_wr_done",       DW'(wr_done),       '0);
    check("rst_rd_cmd_ready",  DW'(rd_cmd_ready),  '0);
    check("rst_rd_resp_valid", DW'(rd_resp_valid), '0);
    tick;
    tick;
    rst = 1'b0;
    #1;
    check("post_rst_wr_ready", DW'(wr_cmd_ready), DW'(4'hF));
    check("post_rst_rd_ready", DW'(rd_cmd_ready), DW'(4'hF));

    foreach (vecs[k]) begin
      do_write(vecs[k].seg, vecs[k].addr, vecs[k].data, vecs[k].be);
      if (vecs[k].do_rd) do_read(vecs[k].seg, vecs[k].addr, vecs[k].exp);
    end

    // Backpressure on seg2: two reads fill the pipe, the third stalls
    rd_resp_ready[2] = 1'b0;
    rd_cmd_addr[2*AW +: AW] = 12'h001;
    rd_cmd_valid[2] = 1'b1;
    #1;
    check("bp_ready_a1", DW'(rd_cmd_ready[2]), DW'(1));
    tick;
    rd_cmd_addr[2*AW +: AW] = 12'h002;
    #1;
    check("bp_ready_a2", DW'(rd_cmd_ready[2]), DW'(1));
    tick;
    rd_cmd_addr[2*AW +: AW] = 12'h003;
    #1;
    check("bp_ready_full", DW'(rd_cmd_ready[2]), DW'(0));
    check("bp_hold_valid", DW'(rd_resp_valid[2]), DW'(1));
    check("bp_hold_data",  seg_data(2), D_R1);
    tick;
    check("bp_still_full", DW'(rd_cmd_ready[2]), DW'(0));
    check("bp_stable_data", seg_data(2), D_R1);
    rd_resp_ready[2] = 1'b1;
    #1;
    check("bp_release_ready", DW'(rd_cmd_ready[2]), DW'(1));
    check("bp_resp1", seg_data(2), D_R1);
    tick;
    rd_cmd_valid = '0;
    check("bp_resp2_valid", DW'(rd_resp_valid[2]), DW'(1));
    check("bp_resp2", seg_data(2), D_R2);
    tick;
    check("bp_resp3_valid", DW'(rd_resp_valid[2]), DW'(1));
    check("bp_resp3", seg_data(2), D_R3);
    tick;
    check("bp_drained", DW'(rd_resp_valid[2]), DW'(0));

    // Parallel reads of the top address, seg3 backpressured
    rd_resp_ready = 4'b0111;
    for (int s = 0; s < SC; s++) rd_cmd_addr[s*AW +: AW] = 12'hFFF;
    rd_cmd_valid = 4'hF;
    #1;
    check("par_cmd_ready", DW'(rd_cmd_ready), DW'(4'hF));
    tick;
    rd_cmd_valid = '0;
    check("par_n1_valid", DW'(rd_resp_valid), '0);
    tick;
    check("par_n2_valid", DW'(rd_resp_valid), DW'(4'hF));
    check("par_seg0", seg_data(0), D_S0);
    check("par_seg1", seg_data(1), D_S1);
    check("par_seg2", seg_data(2), D_S2);
    check("par_seg3", seg_data(3), D_S3);
    tick;
    check("par_n3_valid", DW'(rd_resp_valid), DW'(4'b1000));
    check("par_seg3_hold", seg_data(3), D_S3);
    tick;
    check("par_seg3_hold2", seg_data(3), D_S3);
    rd_resp_ready = 4'hF;
    tick;
    check("par_drained", DW'(rd_resp_valid), '0);

    // Same-cycle read/write collision on seg0 addr 7: read-first
    wr_cmd_addr[0 +: AW] = 12'h007;
    wr_cmd_data[0 +: DW] = D_AA;
    wr_cmd_be[0 +: BW]   = 16'hFFFF;
    wr_cmd_valid[0]      = 1'b1;
    rd_cmd_addr[0 +: AW] = 12'h007;
    rd_cmd_valid[0]      = 1'b1;
    tick;
    wr_cmd_valid = '0;
    rd_cmd_valid = '0;
    check("col_wr_done", DW'(wr_done[0]), DW'(1));
    tick;
    check("col_valid", DW'(rd_resp_valid[0]), DW'(1));
    check("col_old_data", seg_data(0), D_55);
    tick;
    do_read(0, 12'h007, D_AA);

    // Reset with two reads outstanding on seg1
    rd_resp_ready[1] = 1'b0;
    rd_cmd_addr[1*AW +: AW] = 12'hFFF;
    rd_cmd_valid[1] = 1'b1;
    tick;
    tick;
    rd_cmd_valid = '0;
    check("rst_mid_valid_before", DW'(rd_resp_valid[1]), DW'(1));
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_valid_async", DW'(rd_resp_valid), '0);
    check("rst_mid_rd_ready",    DW'(rd_cmd_ready),  '0);
    check("rst_mid_wr_ready",    DW'(wr_cmd_ready),  '0);
    tick;
    tick;
    rst = 1'b0;
    rd_resp_ready = 4'hF;
    #1;
    check("rst_rel_rd_ready", DW'(rd_cmd_ready), DW'(4'hF));
    for (int c = 0; c < 3; c++) begin
      tick;
      check("rst_no_stale", DW'(rd_resp_valid), '0);
    end
    do_read(1, 12'hFFF, D_S1);
    do_read(0, 12'h010, D_HELLO);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
